// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: shared defaults and fill-width helper for seq_detector_param
package seq_detector_pkg;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    localparam int         DEF_CNT_W   = 8;

    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: saturating up-counter, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector, Mealy/Moore, runtime overlap; SEQ_DETECTOR_PROG_PATTERN_EN adds a loadable pattern
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit                 MOORE   = 1'b0,
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SEQ_DETECTOR_PROG_PATTERN_EN
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
`endif
    input  logic               x,
    input  logic               en,
    input  logic               overlap,
    output logic               z,
    output logic [CNT_W-1:0]   match_count
);

    localparam int            FW     = fill_w(PAT_LEN);
    localparam logic [FW-1:0] FULL   = FW'(PAT_LEN);
    localparam logic [FW-1:0] THRESH = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               z_q, z_d;
    logic [PAT_LEN-1:0] cand;
    logic [PAT_LEN-1:0] pat;
    logic               load;
    logic               hit;

`ifdef SEQ_DETECTOR_PROG_PATTERN_EN
    logic [PAT_LEN-1:0] pat_reg_q, pat_reg_d;

    always_comb begin
        pat_reg_d = pat_load ? pat_in : pat_reg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pat_reg_q <= PATTERN;
        else     pat_reg_q <= pat_reg_d;
    end

    assign pat  = pat_reg_q;
    assign load = pat_load;
`else
    assign pat  = PATTERN;
    assign load = 1'b0;
`endif

    assign cand = {hist_q[PAT_LEN-2:0], x};
    // fill guards against the zero-filled history after reset/clear matching
    assign hit  = en && !rst && !load && (fill_q >= THRESH) && (cand == pat);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = hit;
        if (load || (hit && !overlap)) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = cand;
            fill_d = (hit || fill_q == FULL) ? FULL : fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .count (match_count)
    );

    assign z = MOORE ? z_q : hit;

endmodule
